// File: rtl/uart_pkg.sv
// Shared UART constants for the expansion card.
// Used by the receiver, transmitter and receive FIFO.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;
   localparam int UART_CLK_DIVIDE = 868;
   localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_mem.sv
// Byte storage for the receive FIFO.
// Synchronous write port, combinational read port.
module fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                       i_clk,
   input  logic                       i_we,
   input  logic [AW-1:0]              i_wrAddr,
   input  logic [UART_DATA_WIDTH-1:0] i_wrData,
   input  logic [AW-1:0]              i_rdAddr,
   output logic [UART_DATA_WIDTH-1:0] o_rdData
);

   logic [UART_DATA_WIDTH-1:0] mem [DEPTH];

   // store one byte per enabled cycle
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_wrAddr] <= i_wrData;
      end
   end

   assign o_rdData = mem[i_rdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver.
// First-word-fall-through, threshold irq, sticky overrun.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH     = UART_FIFO_DEPTH,
   parameter int THRESHOLD = 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_valid,
   input  logic [UART_DATA_WIDTH-1:0] i_data,
   input  logic                       i_read,
   input  logic                       i_clearOverrun,
   output logic [UART_DATA_WIDTH-1:0] o_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overrun,
   output logic                       o_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] THR_C   = CW'(THRESHOLD);

   logic [AW-1:0]              wr_ptr;
   logic [AW-1:0]              rd_ptr;
   logic [CW-1:0]              count;
   logic                       overrun;
   logic                       empty;
   logic                       full;
   logic                       wr_ok;
   logic                       rd_ok;
   logic                       drop;
   logic [UART_DATA_WIDTH-1:0] rd_data;

   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);

   // a full FIFO still takes a byte when a pop frees a slot this cycle
   assign wr_ok = i_valid & (~full | i_read);
   assign rd_ok = i_read & ~empty;
   assign drop  = i_valid & full & ~i_read;

   fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_clk    (i_clk),
      .i_we     (wr_ok),
      .i_wrAddr (wr_ptr),
      .i_wrData (i_data),
      .i_rdAddr (rd_ptr),
      .o_rdData (rd_data)
   );

   // advance pointers on accepted transfers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // occupancy tracks accepted writes minus accepted reads
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count <= '0;
      end else begin
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // sticky overrun; a new drop beats a clear in the same cycle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (i_clearOverrun) begin
         overrun <= 1'b0;
      end
   end

   assign o_data    = empty ? '0 : rd_data;
   assign o_empty   = empty;
   assign o_full    = full;
   assign o_count   = count;
   assign o_overrun = overrun;
   assign o_irq     = (count >= THR_C);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Popped bytes are checked against a queue filled at write time.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vld = 1'b0;
   logic [7:0] din = 8'h00;
   logic       rd  = 1'b0;
   logic       clr = 1'b0;

   logic [7:0] dout;
   logic       empty, full, ovr, irq;
   logic [4:0] cnt;

   logic [7:0] dout4;
   logic       empty4, full4, ovr4, irq4;
   logic [4:0] cnt4;

   int n_checks = 0;
   int n_fail   = 0;
   int max_cnt;

   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(16), .THRESHOLD(1)) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_valid        (vld),
      .i_data         (din),
      .i_read         (rd),
      .i_clearOverrun (clr),
      .o_data         (dout),
      .o_empty        (empty),
      .o_full         (full),
      .o_count        (cnt),
      .o_overrun      (ovr),
      .o_irq          (irq)
   );

   uart_rx_fifo #(.DEPTH(16), .THRESHOLD(4)) dut4 (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_valid        (vld),
      .i_data         (din),
      .i_read         (rd),
      .i_clearOverrun (clr),
      .o_data         (dout4),
      .o_empty        (empty4),
      .o_full         (full4),
      .o_count        (cnt4),
      .o_overrun      (ovr4),
      .o_irq          (irq4)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [7:0] d,
                      input logic r, input logic c);
      vld = v;
      din = d;
      rd  = r;
      clr = c;
      @(posedge clk);
      #1;
      vld = 1'b0;
      rd  = 1'b0;
      clr = 1'b0;
   endtask

   task automatic push_wr(input logic [7:0] d, input logic r);
      exp_q.push_back(d);
      cyc(1'b1, d, r, 1'b0);
   endtask

   // monitor: every accepted pop is compared with the queue head
   always @(negedge clk) begin
      if (!rst && rd && !empty) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected got=%0h exp=none", dout);
         end else begin
            check("pop_data", 32'(dout), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      check("rst_empty", 32'(empty), 1);
      check("rst_full",  32'(full),  0);
      check("rst_count", 32'(cnt),   0);
      check("rst_irq",   32'(irq),   0);
      check("rst_ovr",   32'(ovr),   0);
      check("rst_data",  32'(dout),  0);

      push_wr(8'hA5, 1'b0);
      check("a5_empty", 32'(empty), 0);
      check("a5_count", 32'(cnt),   1);
      check("a5_data",  32'(dout),  32'hA5);
      check("a5_irq",   32'(irq),   1);
      check("a5_irq4",  32'(irq4),  0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("a5_pop_empty", 32'(empty), 1);
      check("a5_pop_data",  32'(dout),  0);

      for (int i = 0; i < 16; i++) begin
         push_wr(8'(i), 1'b0);
      end
      check("fill_full",  32'(full), 1);
      check("fill_count", 32'(cnt),  16);
      check("fill_irq4",  32'(irq4), 1);
      cyc(1'b1, 8'hFF, 1'b0, 1'b0);
      check("ovf_ovr",   32'(ovr), 1);
      check("ovf_count", 32'(cnt), 16);

      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("clr_alone", 32'(ovr), 0);

      push_wr(8'h55, 1'b1);
      check("fwr_count", 32'(cnt),  16);
      check("fwr_full",  32'(full), 1);
      check("fwr_ovr",   32'(ovr),  0);

      cyc(1'b1, 8'hEE, 1'b0, 1'b1);
      check("clr_set_ovr",   32'(ovr), 1);
      check("clr_set_count", 32'(cnt), 16);

      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check("drain_empty", 32'(empty), 1);
      check("drain_count", 32'(cnt),   0);

      push_wr(8'h3C, 1'b1);
      check("ewr_count", 32'(cnt),  1);
      check("ewr_data",  32'(dout), 32'h3C);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("erd_empty", 32'(empty), 1);
      check("erd_count", 32'(cnt),   0);
      check("erd_data",  32'(dout),  0);
      check("erd_ovr",   32'(ovr),   1);

      max_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         push_wr(8'(8'h40 + i), 1'b0);
         if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
      end
      check("wrap_maxcnt_le2", 32'(max_cnt <= 2), 1);
      check("wrap_empty",      32'(empty),        1);

      push_wr(8'h01, 1'b0);
      push_wr(8'h02, 1'b0);
      push_wr(8'h03, 1'b0);
      check("thr_cnt3_irq4", 32'(irq4), 0);
      check("thr_cnt3_irq1", 32'(irq),  1);
      push_wr(8'h04, 1'b0);
      check("thr_cnt4_irq4", 32'(irq4), 1);
      push_wr(8'h05, 1'b0);
      check("thr_cnt5",      32'(cnt),  5);

      exp_q.delete();
      rst = 1'b1;
      cyc(1'b1, 8'h99, 1'b1, 1'b0);
      rst = 1'b0;
      check("mrst_empty", 32'(empty), 1);
      check("mrst_full",  32'(full),  0);
      check("mrst_count", 32'(cnt),   0);
      check("mrst_irq",   32'(irq),   0);
      check("mrst_irq4",  32'(irq4),  0);
      check("mrst_ovr",   32'(ovr),   0);
      check("mrst_data",  32'(dout),  0);

      push_wr(8'h77, 1'b0);
      check("post_rst_data", 32'(dout), 32'h77);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("queue_drained", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
